// File: rtl/controle_alarme_if.sv
// controle_alarme_if: alarm controller bus.
//   Alarme, Reconhecer : detector alarm level and operator acknowledge (master -> slave)
//   Sirene, Disparado  : siren drive and latched alarm indicator (slave -> master)
//   Eventos            : saturating count of accepted alarm events (slave -> master)
//   Timeout            : one-cycle pulse when the siren auto-silences (slave -> master)
interface controle_alarme_if #(
    parameter int CNT_BITS = 4
);
    logic                Alarme;
    logic                Reconhecer;
    logic                Sirene;
    logic                Disparado;
    logic [CNT_BITS-1:0] Eventos;
    logic                Timeout;
    modport master (output Alarme, Reconhecer, input Sirene, Disparado, Eventos, Timeout);
    modport slave  (input Alarme, Reconhecer, output Sirene, Disparado, Eventos, Timeout);
endinterface

// File: rtl/controle_alarme.sv
// controle_alarme: latches detector alarms, drives a timed siren, counts events, acknowledge + cooldown.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : controle_alarme_if slave (Alarme, Reconhecer in; Sirene, Disparado, Eventos, Timeout out)
//   Macro CONTROLE_ALARME_BLINK_EN: defined -> siren blinks with half-period BLINK_HALF;
//   undefined -> steady siren while sounding, no blink counter.
module controle_alarme #(
    parameter int CNT_BITS   = 4,
    parameter int BLINK_HALF = 4,
    parameter int TIMEOUT    = 32,
    parameter int COOLDOWN   = 8
) (
    input logic clk,
    input logic reset,
    controle_alarme_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = $clog2(COOLDOWN + 1);

    if (TIMEOUT < 2 || COOLDOWN < 1 || BLINK_HALF < 1) begin : g_bad_params
        $error("controle_alarme: invalid TIMEOUT/COOLDOWN/BLINK_HALF");
    end

    typedef enum logic [1:0] {IDLE, SOUNDING, SILENCED, COOLING} state_t;

    state_t              state_q, state_d;
    logic                alarme_q;
    logic [CNT_BITS-1:0] eventos_q, eventos_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [CW-1:0]       cool_q, cool_d;
    logic                timeout_q, timeout_d;
    logic                evento, restart;

    always_comb begin
        evento    = bus.Alarme & ~alarme_q;
        // restart: event that (re)starts the siren; acknowledge pre-empts it while latched
        restart   = evento & ((state_q == IDLE) | ((state_q != COOLING) & ~bus.Reconhecer));
        eventos_d = (evento && state_q != COOLING && eventos_q != '1) ? eventos_q + 1'b1 : eventos_q;
        timer_d   = restart ? '0 : (state_q == SOUNDING ? timer_q + 1'b1 : timer_q);
        cool_d    = cool_q;
        timeout_d = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE:     state_d = evento ? SOUNDING : IDLE;
            SOUNDING: begin
                if (bus.Reconhecer) begin
                    state_d = COOLING;
                    cool_d  = CW'(COOLDOWN - 1);
                end else if (!evento && timer_q == TW'(TIMEOUT - 1)) begin
                    state_d   = SILENCED;
                    timeout_d = 1'b1;
                end
            end
            SILENCED: begin
                if (bus.Reconhecer) begin
                    state_d = COOLING;
                    cool_d  = CW'(COOLDOWN - 1);
                end else if (evento) begin
                    state_d = SOUNDING;
                end
            end
            default: begin
                if (cool_q == '0) state_d = IDLE;
                else cool_d = cool_q - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            alarme_q  <= 1'b0;
            eventos_q <= '0;
            timer_q   <= '0;
            cool_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alarme_q  <= bus.Alarme;
            eventos_q <= eventos_d;
            timer_q   <= timer_d;
            cool_q    <= cool_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef CONTROLE_ALARME_BLINK_EN
    localparam int BW = $clog2(2 * BLINK_HALF);
    logic [BW-1:0] blink_q, blink_d;

    always_comb begin
        blink_d = restart ? '0 :
                  (state_q != SOUNDING) ? blink_q :
                  (blink_q == BW'(2 * BLINK_HALF - 1)) ? '0 : blink_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) blink_q <= '0;
        else        blink_q <= blink_d;
    end

    assign bus.Sirene = (state_q == SOUNDING) & (blink_q < BW'(BLINK_HALF));
`else
    assign bus.Sirene = (state_q == SOUNDING);
`endif

    assign bus.Disparado = (state_q == SOUNDING) | (state_q == SILENCED);
    assign bus.Eventos   = eventos_q;
    assign bus.Timeout   = timeout_q;
endmodule

// File: doc/controle_alarme.md
# controle_alarme

Alarm controller sitting directly downstream of the lamp-sequence detector. It consumes the detector's `Alarme` output and turns each detected 1-2-3 sequence into a latched alarm condition. It drives a timed, optionally blinking siren, keeps a saturating event count, and is cleared by an acknowledge input followed by a fixed cooldown window.

## Interface
- `CNT_BITS`, 4: width of the event counter.
- `BLINK_HALF`, 4: siren half-period in cycles (on for BLINK_HALF, off for BLINK_HALF).
- `TIMEOUT`, 32: cycles the siren sounds before auto-silencing (≥2).
- `COOLDOWN`, 8: cycles after acknowledge during which new alarms are ignored (≥1).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Alarme`  in  1  alarm level from the sequence detector, synchronous to clk.
- `Reconhecer`  in  1  operator acknowledge, level-sampled each cycle.
- `Sirene`  out  1  siren drive.
- `Disparado`  out  1  latched alarm indicator.
- `Eventos`  out  CNT_BITS  count of accepted alarm events, saturating.
- `Timeout`  out  1  one-cycle pulse when the siren auto-silences.

## Operation
- Event detect: register `Alarme_d`, reset value 0. `evento = Alarme & ~Alarme_d`. A level held high counts once.
- State machine, 2-bit enum: IDLE, SOUNDING, SILENCED, COOLDOWN. Reset state is IDLE.
- **IDLE**
  - `evento` → SOUNDING; `Eventos`++; siren timer and blink counter cleared.
- **SOUNDING**
  - Timer increments every cycle.
  - `Reconhecer` → COOLDOWN.
  - Otherwise, `evento` → stay in SOUNDING; `Eventos`++; timer and blink counter restart from 0.
  - Otherwise, timer == TIMEOUT-1 → SILENCED; `Timeout` pulses.
- **SILENCED**
  - `Reconhecer` → COOLDOWN.
  - Otherwise, `evento` → SOUNDING; `Eventos`++; timers cleared.
- **COOLDOWN**
  - Down-counter loaded with COOLDOWN-1 on entry; exit to IDLE when it reaches 0.
  - `evento` is ignored and not counted.
  - `Reconhecer` has no effect.
- Simultaneous `Reconhecer` and `evento` in SOUNDING or SILENCED: acknowledge wins (go to COOLDOWN). The event is still counted.
- `Eventos`: increments by 1 per accepted event and saturates at 2^CNT_BITS-1. Only reset clears it.
- Outputs, decoded from registered state (no input-to-output combinational path):
  - `Disparado` = state ∈ {SOUNDING, SILENCED}.
  - `Sirene` = (state == SOUNDING) & blink phase.
  - Blink phase is 1 for blink counts 0..BLINK_HALF-1 and 0 for BLINK_HALF..2·BLINK_HALF-1, then wraps.
  - `Timeout` is a registered pulse.
- Reset asserted mid-operation: immediately forces IDLE, `Eventos`=0, all timers 0, all outputs 0, `Alarme_d`=0.

## Timing
- Reset values: `Sirene`=0, `Disparado`=0, `Eventos`=0, `Timeout`=0.
- Alarm latency: `Alarme` rises before edge k → state = SOUNDING after edge k. `Sirene`, `Disparado` and the new `Eventos` value are all visible in cycle k+1.
- Auto-silence: with no acknowledge or new event, SOUNDING lasts exactly TIMEOUT cycles. `Timeout` is high for the single cycle in which the state first reads SILENCED.
- Acknowledge: `Reconhecer` sampled at edge a → `Sirene` and `Disparado` are 0 from cycle a+1. COOLDOWN lasts exactly COOLDOWN cycles before returning to IDLE.
- A one-cycle `Alarme` pulse (the detector's normal behaviour) is sufficient to trigger.

## Configuration
- Macro: `CONTROLE_ALARME_BLINK_EN`.
- Defined: `Sirene` blinks as described above.
- Undefined:
  - `Sirene` = (state == SOUNDING), steady.
  - The blink counter is not synthesized.
  - `BLINK_HALF` is unused.
- All other behaviour is identical in both builds.

## Test plan
- Reset then single event: `reset` low 2 cycles, release, pulse `Alarme` for 1 cycle → next cycle `Disparado`=1, `Eventos`=1. With blink enabled and BLINK_HALF=4, `Sirene` runs 1,1,1,1,0,0,0,0,…
- Timeout: TIMEOUT=32, no acknowledge → `Sirene` stops after 32 SOUNDING cycles, `Timeout` pulses for 1 cycle, `Disparado` stays 1.
- Acknowledge and cooldown: acknowledge at cycle 10 of SOUNDING → `Disparado`=0 next cycle. An `Alarme` pulse 3 cycles later is ignored (`Eventos` unchanged). Another pulse 9 cycles after the acknowledge retriggers the alarm, `Eventos`=2.
- Re-trigger and saturation: CNT_BITS=4, 20 `Alarme` pulses spaced 3 cycles apart without acknowledge → `Eventos` stops at 15. Each pulse restarts the timer, so `Timeout` never fires.
- Simultaneous events: `Reconhecer` and an `Alarme` edge in the same cycle during SOUNDING → COOLDOWN entered, `Eventos`+1.
- Async reset mid-alarm: drop `reset` between clock edges while in SOUNDING → all outputs 0 immediately, without waiting for the next edge. After release, the FSM is in IDLE.
